// File: rtl/rx_dll_seq_ack_if.sv
// Bundles the receive-side link signals: frames in from the PHY, frames out to
// the transaction layer, and the outgoing ACK/NAK DLLP stream.
interface rx_dll_seq_ack_if #(
  parameter int DATA_W = 1024
);
  logic [DATA_W-1:0] tlp_data_in;
  logic              tlp_data_in_valid;
  logic              tlp_data_out_ready;
  logic [31:0]       dllp;
  logic              dllp_valid;
  logic              dllp_ready;
  logic [DATA_W-1:0] tlp_data_out;
  logic              tlp_data_out_valid;
  logic              tlp_data_in_ready;
  logic [11:0]       exp_seq;

  modport master (
    output tlp_data_in, tlp_data_in_valid, dllp_ready, tlp_data_in_ready,
    input  tlp_data_out_ready, dllp, dllp_valid, tlp_data_out,
           tlp_data_out_valid, exp_seq
  );

  modport slave (
    input  tlp_data_in, tlp_data_in_valid, dllp_ready, tlp_data_in_ready,
    output tlp_data_out_ready, dllp, dllp_valid, tlp_data_out,
           tlp_data_out_valid, exp_seq
  );
endinterface

// File: rtl/rx_dll_seq_ack.sv
// Receive data link layer: LCRC and sequence check, show-ahead TL FIFO and
// coalesced ACK / collapsed NAK DLLP generation.
module rx_dll_seq_ack #(
  parameter int DATA_W      = 1024,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_COUNT   = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input logic           clk,
  input logic           reset_n,
  rx_dll_seq_ack_if.slave bus
);

  localparam int NW = DATA_W / 32;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = $clog2(ACK_COUNT + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0] TYPE_ACK = 8'h00;
  localparam logic [7:0] TYPE_NAK = 8'h10;

  // XOR of every 32-bit word above the LCRC field
  function automatic logic [31:0] lcrc_calc(input logic [DATA_W-1:0] frame);
    logic [31:0] acc;
    acc = 32'h0;
    for (int i = 1; i < NW; i++) begin
      acc = acc ^ frame[i*32 +: 32];
    end
    return acc;
  endfunction

  logic [11:0]       r_exp_seq;
  logic              r_nak_sched;
  logic              r_nak_req;
  logic              r_ack_pend;
  logic              r_ack_force;
  logic [KW-1:0]     r_ack_cnt;
  logic [TW-1:0]     r_ack_tmr;
  logic [31:0]       r_dllp;
  logic              r_dllp_valid;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic          w_full, w_empty, w_accept, w_push, w_pop;
  logic          w_lcrc_ok, w_in_order, w_dup;
  logic [11:0]   w_seq, w_dist, w_exp_next, w_dllp_seq;
  logic          w_nak_sched_next, w_nak_raise, w_dup_hit, w_inorder_hit;
  logic          w_nak_req, w_ack_req, w_load_ok, w_load_nak, w_load_ack;
  logic          w_ack_pend_next, w_ack_force_next;
  logic [KW-1:0] w_ack_cnt_next;
  logic [TW-1:0] w_ack_tmr_next;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == {CW{1'b0}});
  assign w_accept   = bus.tlp_data_in_valid & ~w_full;
  assign w_pop      = ~w_empty & bus.tlp_data_in_ready;
  assign w_seq      = bus.tlp_data_in[DATA_W-5 -: 12];
  assign w_dist     = r_exp_seq - w_seq;
  assign w_lcrc_ok  = (lcrc_calc(bus.tlp_data_in) == bus.tlp_data_in[31:0]);
  assign w_in_order = (w_dist == 12'd0);
  assign w_dup      = (w_dist >= 12'd1) && (w_dist <= 12'd2048);

  // Per-frame classification: bad LCRC, in-order, duplicate, out-of-sequence
  always_comb begin
    w_exp_next       = r_exp_seq;
    w_nak_sched_next = r_nak_sched;
    w_nak_raise      = 1'b0;
    w_dup_hit        = 1'b0;
    w_inorder_hit    = 1'b0;
    w_push           = 1'b0;
    if (w_accept) begin
      if (w_lcrc_ok && w_in_order) begin
        w_push           = 1'b1;
        w_inorder_hit    = 1'b1;
        w_exp_next       = r_exp_seq + 12'd1;
        w_nak_sched_next = 1'b0;
      end else if (w_lcrc_ok && w_dup) begin
        w_dup_hit = 1'b1;
      end else if (!r_nak_sched) begin
        w_nak_sched_next = 1'b1;
        w_nak_raise      = 1'b1;
      end else begin
        w_nak_sched_next = r_nak_sched;
      end
    end else begin
      w_exp_next = r_exp_seq;
    end
  end

  assign w_nak_req  = r_nak_req | w_nak_raise;
  assign w_ack_req  = w_dup_hit | r_ack_force |
                      (r_ack_pend & ((r_ack_cnt >= KW'(ACK_COUNT)) |
                                     (r_ack_tmr >= TW'(ACK_TIMEOUT))));
  assign w_load_ok  = ~r_dllp_valid | bus.dllp_ready;
  assign w_load_nak = w_load_ok & w_nak_req;
  assign w_load_ack = w_load_ok & ~w_nak_req & w_ack_req;
  // The DLLP acknowledges everything up to and including this cycle's frame
  assign w_dllp_seq = w_exp_next - 12'd1;

  // ACK coalescing state; any loaded DLLP acknowledges all received frames
  always_comb begin
    w_ack_pend_next  = r_ack_pend;
    w_ack_force_next = r_ack_force;
    w_ack_cnt_next   = r_ack_cnt;
    w_ack_tmr_next   = r_ack_tmr;
    if (w_load_nak || w_load_ack) begin
      w_ack_pend_next  = 1'b0;
      w_ack_force_next = 1'b0;
      w_ack_cnt_next   = {KW{1'b0}};
      w_ack_tmr_next   = {TW{1'b0}};
    end else begin
      w_ack_pend_next  = r_ack_pend | w_inorder_hit | w_dup_hit;
      w_ack_force_next = r_ack_force | w_dup_hit;
      if (w_inorder_hit && (r_ack_cnt < KW'(ACK_COUNT))) begin
        w_ack_cnt_next = r_ack_cnt + KW'(1);
      end else begin
        w_ack_cnt_next = r_ack_cnt;
      end
      if (r_ack_pend && (r_ack_tmr < TW'(ACK_TIMEOUT))) begin
        w_ack_tmr_next = r_ack_tmr + TW'(1);
      end else begin
        w_ack_tmr_next = r_ack_tmr;
      end
    end
  end

  // Sequence, NAK and ACK bookkeeping registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exp_seq   <= 12'd0;
      r_nak_sched <= 1'b0;
      r_nak_req   <= 1'b0;
      r_ack_pend  <= 1'b0;
      r_ack_force <= 1'b0;
      r_ack_cnt   <= {KW{1'b0}};
      r_ack_tmr   <= {TW{1'b0}};
    end else begin
      r_exp_seq   <= w_exp_next;
      r_nak_sched <= w_nak_sched_next;
      r_nak_req   <= w_nak_req & ~w_load_nak;
      r_ack_pend  <= w_ack_pend_next;
      r_ack_force <= w_ack_force_next;
      r_ack_cnt   <= w_ack_cnt_next;
      r_ack_tmr   <= w_ack_tmr_next;
    end
  end

  // DLLP output register; held while the consumer stalls, NAK wins over ACK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dllp       <= 32'h0;
      r_dllp_valid <= 1'b0;
    end else if (w_load_nak) begin
      r_dllp       <= {TYPE_NAK, 12'h000, w_dllp_seq};
      r_dllp_valid <= 1'b1;
    end else if (w_load_ack) begin
      r_dllp       <= {TYPE_ACK, 12'h000, w_dllp_seq};
      r_dllp_valid <= 1'b1;
    end else if (w_load_ok) begin
      r_dllp_valid <= 1'b0;
    end else begin
      r_dllp_valid <= r_dllp_valid;
    end
  end

  // Show-ahead FIFO towards the transaction layer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.tlp_data_in;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.tlp_data_out_ready = ~w_full;
  assign bus.tlp_data_out       = r_mem[r_rd_ptr];
  assign bus.tlp_data_out_valid = ~w_empty;
  assign bus.dllp               = r_dllp;
  assign bus.dllp_valid         = r_dllp_valid;
  assign bus.exp_seq            = r_exp_seq;

endmodule

// File: tb/tb_rx_dll_seq_ack.sv
// Directed bench for rx_dll_seq_ack: in-order forwarding, ACK coalescing and
// timeout, NAK on bad sequence/LCRC, duplicates, backpressure and async reset.
module tb_rx_dll_seq_ack;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int              acc_cyc[$];
  logic [DW-1:0]   out_dat[$];
  int              out_cyc[$];
  logic [31:0]     dl_val[$];
  int              dl_cyc[$];

  rx_dll_seq_ack_if #(.DATA_W(DW)) ifc ();

  rx_dll_seq_ack #(.DATA_W(DW), .FIFO_DEPTH(4), .ACK_COUNT(4), .ACK_TIMEOUT(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake one half-cycle before the edge that completes it
  always @(negedge clk) begin
    if (reset_n) begin
      if (ifc.tlp_data_in_valid && ifc.tlp_data_out_ready) acc_cyc.push_back(cyc);
      if (ifc.tlp_data_out_valid && ifc.tlp_data_in_ready) begin
        out_dat.push_back(ifc.tlp_data_out);
        out_cyc.push_back(cyc);
      end
      if (ifc.dllp_valid && ifc.dllp_ready) begin
        dl_val.push_back(ifc.dllp);
        dl_cyc.push_back(cyc);
      end
    end
  end

  // seq in [123:112], payload in [95:32], LCRC = XOR of the three upper words
  function automatic logic [DW-1:0] mk(input logic [11:0] s, input logic [31:0] tag);
    logic [DW-1:0] f;
    f = '0;
    f[123:112] = s;
    f[95:64]   = tag;
    f[63:32]   = ~tag;
    f[31:0]    = f[127:96] ^ f[95:64] ^ f[63:32];
    return f;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input int bound, input bit must, output bit ok);
    bit rdy;
    int n;
    ifc.tlp_data_in = d;
    ifc.tlp_data_in_valid = 1'b1;
    n = 0;
    do begin
      rdy = ifc.tlp_data_out_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < bound);
    ifc.tlp_data_in_valid = 1'b0;
    ok = rdy;
    if (must) begin
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL send_timeout got=not_accepted want=accepted");
      end
    end
  endtask

  task automatic reset_dut;
    reset_n = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic to_exp5;
    bit ok;
    reset_dut();
    ifc.tlp_data_in_ready = 1'b1;
    ifc.dllp_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(mk(12'(i), 32'h5000 + i), 20, 1'b1, ok);
    wait_cycles(10);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_cycles(2);
    total++;
    if (ifc.tlp_data_out_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", ifc.tlp_data_out_ready); end
    total++;
    if (ifc.dllp_valid !== 1'b0) begin bad++; $display("FAIL rst_dllp_valid got=%0b want=0", ifc.dllp_valid); end
    total++;
    if (ifc.dllp !== 32'h0) begin bad++; $display("FAIL rst_dllp got=%h want=0", ifc.dllp); end
    total++;
    if (ifc.tlp_data_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", ifc.tlp_data_out_valid); end
    total++;
    if (ifc.exp_seq !== 12'd0) begin bad++; $display("FAIL rst_exp_seq got=%0d want=0", ifc.exp_seq); end
    total++;
    if (ifc.tlp_data_out !== '0) begin bad++; $display("FAIL rst_out_data got=%h want=0", ifc.tlp_data_out); end
    reset_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_in_order;
    bit ok;
    int a0, o0, d0;
    reset_dut();
    ifc.tlp_data_in_ready = 1'b1;
    ifc.dllp_ready = 1'b1;
    a0 = acc_cyc.size(); o0 = out_dat.size(); d0 = dl_val.size();
    for (int i = 0; i < 4; i++) send(mk(12'(i), 32'h1000 + i), 20, 1'b1, ok);
    wait_cycles(10);
    total++;
    if (out_dat.size() - o0 != 4) begin bad++; $display("FAIL inorder_count got=%0d want=4", out_dat.size() - o0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_dat.size() <= o0 + i || out_dat[o0+i] !== mk(12'(i), 32'h1000 + i)) begin
        bad++; $display("FAIL inorder_data[%0d] got=%h want=%h", i, out_dat[o0+i], mk(12'(i), 32'h1000 + i));
      end
      total++;
      if (out_cyc.size() <= o0 + i || acc_cyc.size() <= a0 + i || out_cyc[o0+i] !== acc_cyc[a0+i] + 1) begin
        bad++; $display("FAIL inorder_latency[%0d] got=%0d want=%0d", i, out_cyc[o0+i], acc_cyc[a0+i] + 1);
      end
    end
    total++;
    if (dl_val.size() - d0 != 1) begin bad++; $display("FAIL inorder_ack_count got=%0d want=1", dl_val.size() - d0); end
    total++;
    if (dl_val.size() <= d0 || dl_val[d0] !== 32'h00000003) begin bad++; $display("FAIL inorder_ack got=%h want=00000003", dl_val[d0]); end
    total++;
    if (ifc.exp_seq !== 12'd4) begin bad++; $display("FAIL inorder_exp_seq got=%0d want=4", ifc.exp_seq); end
  endtask

  task automatic test_ack_timeout;
    bit ok;
    int a, d0, n;
    reset_dut();
    ifc.tlp_data_in_ready = 1'b1;
    ifc.dllp_ready = 1'b1;
    d0 = dl_val.size();
    send(mk(12'd0, 32'h2000), 20, 1'b1, ok);
    a = acc_cyc[acc_cyc.size()-1];
    wait_cycles(63);
    total++;
    if (dl_val.size() != d0) begin bad++; $display("FAIL timeout_early got=%0d want=0 dllps", dl_val.size() - d0); end
    n = 0;
    while (dl_val.size() == d0 && n < 20) begin wait_cycles(1); n++; end
    total++;
    if (dl_val.size() <= d0 || dl_val[d0] !== 32'h00000000) begin bad++; $display("FAIL timeout_ack got=%h want=00000000", dl_val[d0]); end
    total++;
    if (dl_cyc.size() <= d0 || dl_cyc[d0] < a + 65 || dl_cyc[d0] > a + 67) begin
      bad++; $display("FAIL timeout_when got=%0d want=%0d..%0d", dl_cyc[d0], a + 65, a + 67);
    end
  endtask

  task automatic test_out_of_seq;
    bit ok;
    int o0, d0;
    to_exp5();
    o0 = out_dat.size(); d0 = dl_val.size();
    send(mk(12'd7, 32'h3007), 20, 1'b1, ok);
    send(mk(12'd8, 32'h3008), 20, 1'b1, ok);
    wait_cycles(10);
    total++;
    if (dl_val.size() - d0 != 1) begin bad++; $display("FAIL oos_nak_count got=%0d want=1", dl_val.size() - d0); end
    total++;
    if (dl_val.size() <= d0 || dl_val[d0] !== 32'h10000004) begin bad++; $display("FAIL oos_nak got=%h want=10000004", dl_val[d0]); end
    total++;
    if (out_dat.size() != o0) begin bad++; $display("FAIL oos_dropped got=%0d want=0 frames", out_dat.size() - o0); end
    send(mk(12'd5, 32'h3005), 20, 1'b1, ok);
    wait_cycles(3);
    total++;
    if (out_dat.size() <= o0 || out_dat[o0] !== mk(12'd5, 32'h3005)) begin bad++; $display("FAIL oos_recover_data got=%h want=%h", out_dat[o0], mk(12'd5, 32'h3005)); end
    total++;
    if (ifc.exp_seq !== 12'd6) begin bad++; $display("FAIL oos_recover_exp got=%0d want=6", ifc.exp_seq); end
    send(mk(12'd9, 32'h3009), 20, 1'b1, ok);
    wait_cycles(5);
    total++;
    if (dl_val.size() <= d0 + 1 || dl_val[d0+1] !== 32'h10000005) begin bad++; $display("FAIL oos_nak_rearm got=%h want=10000005", dl_val[d0+1]); end
  endtask

  task automatic test_lcrc;
    bit ok;
    int o0, d0;
    logic [DW-1:0] f;
    to_exp5();
    o0 = out_dat.size(); d0 = dl_val.size();
    f = mk(12'd5, 32'h4005);
    f[0] = ~f[0];
    send(f, 20, 1'b1, ok);
    wait_cycles(10);
    total++;
    if (dl_val.size() - d0 != 1 || dl_val[d0] !== 32'h10000004) begin bad++; $display("FAIL lcrc_nak got=%h n=%0d want=10000004 n=1", dl_val[d0], dl_val.size() - d0); end
    total++;
    if (ifc.exp_seq !== 12'd5) begin bad++; $display("FAIL lcrc_exp got=%0d want=5", ifc.exp_seq); end
    total++;
    if (out_dat.size() != o0) begin bad++; $display("FAIL lcrc_dropped got=%0d want=0 frames", out_dat.size() - o0); end
  endtask

  task automatic test_duplicate;
    bit ok;
    int a, o0, d0;
    to_exp5();
    o0 = out_dat.size(); d0 = dl_val.size();
    send(mk(12'd3, 32'h5003), 20, 1'b1, ok);
    a = acc_cyc[acc_cyc.size()-1];
    wait_cycles(5);
    total++;
    if (dl_val.size() <= d0 || dl_val[d0] !== 32'h00000004) begin bad++; $display("FAIL dup_ack got=%h want=00000004", dl_val[d0]); end
    total++;
    if (dl_cyc.size() <= d0 || dl_cyc[d0] > a + 2) begin bad++; $display("FAIL dup_immediate got=%0d want<=%0d", dl_cyc[d0], a + 2); end
    total++;
    if (ifc.exp_seq !== 12'd5 || out_dat.size() != o0) begin bad++; $display("FAIL dup_dropped got=exp%0d/%0d want=exp5/0", ifc.exp_seq, out_dat.size() - o0); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int a0;
    logic [31:0] held;
    reset_dut();
    ifc.tlp_data_in_ready = 1'b0;
    ifc.dllp_ready = 1'b0;
    a0 = acc_cyc.size();
    for (int i = 0; i < 4; i++) send(mk(12'(i), 32'h6000 + i), 20, 1'b1, ok);
    total++;
    if (ifc.tlp_data_out_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b want=0", ifc.tlp_data_out_ready); end
    send(mk(12'd4, 32'h6004), 5, 1'b0, ok);
    total++;
    if (ok || acc_cyc.size() - a0 != 4) begin bad++; $display("FAIL bp_no_accept got=%0d want=4 accepts", acc_cyc.size() - a0); end
    total++;
    if (ifc.tlp_data_out_valid !== 1'b1 || ifc.tlp_data_out !== mk(12'd0, 32'h6000)) begin bad++; $display("FAIL bp_head got=%h want=%h", ifc.tlp_data_out, mk(12'd0, 32'h6000)); end
    total++;
    if (ifc.dllp_valid !== 1'b1 || ifc.dllp !== 32'h00000003) begin bad++; $display("FAIL bp_dllp got=%0b/%h want=1/00000003", ifc.dllp_valid, ifc.dllp); end
    held = ifc.dllp;
    wait_cycles(6);
    total++;
    if (ifc.dllp_valid !== 1'b1 || ifc.dllp !== held) begin bad++; $display("FAIL bp_dllp_stable got=%0b/%h want=1/%h", ifc.dllp_valid, ifc.dllp, held); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (ifc.tlp_data_out_ready !== 1'b1 || ifc.tlp_data_out_valid !== 1'b0) begin bad++; $display("FAIL arst_fifo got=%0b/%0b want=1/0", ifc.tlp_data_out_ready, ifc.tlp_data_out_valid); end
    total++;
    if (ifc.dllp_valid !== 1'b0 || ifc.dllp !== 32'h0) begin bad++; $display("FAIL arst_dllp got=%0b/%h want=0/0", ifc.dllp_valid, ifc.dllp); end
    total++;
    if (ifc.exp_seq !== 12'd0 || ifc.tlp_data_out !== '0) begin bad++; $display("FAIL arst_state got=%0d/%h want=0/0", ifc.exp_seq, ifc.tlp_data_out); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_back_to_back;
    bit ok;
    int o0;
    reset_dut();
    ifc.tlp_data_in_ready = 1'b0;
    ifc.dllp_ready = 1'b1;
    o0 = out_dat.size();
    for (int i = 0; i < 4; i++) send(mk(12'(i), 32'h7000 + i), 20, 1'b1, ok);
    ifc.tlp_data_in_ready = 1'b1;
    wait_cycles(6);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_dat.size() <= o0 + i || out_dat[o0+i] !== mk(12'(i), 32'h7000 + i)) begin
        bad++; $display("FAIL drain_order[%0d] got=%h want=%h", i, out_dat[o0+i], mk(12'(i), 32'h7000 + i));
      end
    end
    total++;
    if (ifc.tlp_data_out_valid !== 1'b0 || ifc.tlp_data_out_ready !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b/%0b want=0/1", ifc.tlp_data_out_valid, ifc.tlp_data_out_ready); end
  endtask

  initial begin
    ifc.tlp_data_in = '0;
    ifc.tlp_data_in_valid = 1'b0;
    ifc.tlp_data_in_ready = 1'b0;
    ifc.dllp_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_in_order();
    test_ack_timeout();
    test_out_of_seq();
    test_lcrc();
    test_duplicate();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
